// File: rtl/regfile_access_seq.sv
// Single-port register file sequencer.
// Serialises operand reads and writebacks.
module regfile_access_seq #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  input  logic            req_use2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rs1,
  output logic [XLEN-1:0] rsp_rs2,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr,
  output logic [XLEN-1:0] rf_d,
  input  logic [XLEN-1:0] rf_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_CAP2,
    S_RSP
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic            use2_q, use2_d;
  logic [XLEN-1:0] rsp1_q, rsp1_d;
  logic [XLEN-1:0] rsp2_q, rsp2_d;

  logic is_idle;
  logic wb_fire;
  logic wb_live;
  logic req_fire;

  assign is_idle  = (state_q == S_IDLE);
  assign wb_fire  = is_idle & wb_valid;
  assign wb_live  = wb_fire & (wb_rd != '0);
  assign req_fire = is_idle & ~wb_valid
                  & req_valid;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: writebacks keep us in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_fire) state_d = S_RD1;
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        if (use2_q) state_d = S_CAP2;
        else        state_d = S_RSP;
      end
      S_CAP2: state_d = S_RSP;
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture; x0 always reads as 0.
  always_comb begin
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    use2_d = use2_q;
    rsp1_d = rsp1_q;
    rsp2_d = rsp2_q;
    unique case (1'b1)
      req_fire: begin
        rs1_d  = req_rs1;
        rs2_d  = req_rs2;
        use2_d = req_use2;
      end
      (state_q == S_RD2): begin
        rsp1_d = (rs1_q == '0) ? '0 : rf_q;
        if (!use2_q) rsp2_d = '0;
      end
      (state_q == S_CAP2): begin
        rsp2_d = (rs2_q == '0) ? '0 : rf_q;
      end
      default: ;
    endcase
  end

  // Latched request fields and response data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      use2_q <= 1'b0;
      rsp1_q <= '0;
      rsp2_q <= '0;
    end else begin
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      use2_q <= use2_d;
      rsp1_q <= rsp1_d;
      rsp2_q <= rsp2_d;
    end
  end

  // Port drive: writes only in IDLE.
  always_comb begin
    req_ready = is_idle & ~wb_valid;
    wb_ready  = is_idle;
    rsp_valid = (state_q == S_RSP);
    rf_we     = wb_live;
    rf_addr   = '0;
    rf_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (wb_fire) rf_addr = wb_rd;
        if (wb_live) rf_d = wb_data;
      end
      S_RD1:   rf_addr = rs1_q;
      S_RD2:   rf_addr = rs2_q;
      S_CAP2:  rf_addr = rs2_q;
      default: rf_addr = '0;
    endcase
  end

  assign rsp_rs1 = rsp1_q;
  assign rsp_rs2 = rsp2_q;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Directed and randomised checks for
// regfile_access_seq with an RF model.
module tb_regfile_access_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic        req_use2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rs1, rsp_rs2;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_d, rf_q;

  logic        rf_clr;
  logic [31:0] mem [32];
  logic [31:0] ref_rf [32];

  int errors = 0;
  int checks = 0;
  int bad_we = 0;

  always #5 clk = ~clk;

  regfile_access_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_use2  (req_use2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rs1   (rsp_rs1),
    .rsp_rs2   (rsp_rs2),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_d      (rf_d),
    .rf_q      (rf_q)
  );

  // Physical RF: x0 storage holds junk so the
  // sequencer must zero it itself.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= (i == 0) ? 32'hBAD0BAD0 : 32'h0;
      rf_q <= 32'h0;
    end else if (rf_we) begin
      mem[rf_addr] <= rf_d;
    end else begin
      rf_q <= mem[rf_addr];
    end
  end

  // A write is only legal while wb_ready (IDLE).
  always @(negedge clk) begin
    if (rstn && rf_we && !wb_ready)
      bad_we <= bad_we + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic do_wb(input logic [4:0] rd,
                       input logic [31:0] d);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
    #1;
    chk("wb_ready", wb_ready, 1);
    chk("wb_rf_we", rf_we, (rd != 0));
    if (rd != 0) begin
      chk("wb_rf_d", rf_d, d);
      ref_rf[rd] = d;
    end
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a,
                       input logic [4:0] b,
                       input logic u);
    bit ok;
    ok = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_rs1   = a;
    req_rs2   = b;
    req_use2  = u;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input logic [31:0] e1,
                          input logic [31:0] e2,
                          input int lat,
                          input int hold);
    int n;
    bit got;
    n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      n++;
      if (rsp_valid) got = 1;
    end
    chk("rsp_seen", got, 1);
    chk("rsp_latency", n, lat);
    chk("rsp_rs1", rsp_rs1, e1);
    chk("rsp_rs2", rsp_rs2, e2);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rs1", rsp_rs1, e1);
      chk("hold_rs2", rsp_rs2, e2);
      chk("hold_wb_ready", wb_ready, 0);
      chk("hold_req_ready", req_ready, 0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("idle_after", wb_ready, 1);
  endtask

  typedef struct {
    bit          is_wb;
    logic [4:0]  a;
    logic [4:0]  b;
    bit          use2;
    logic [31:0] d;
    logic [31:0] e1;
    logic [31:0] e2;
    int          lat;
  } vec_t;

  vec_t vt [10];

  initial begin
    bit seen;
    rstn      = 1'b0;
    rf_clr    = 1'b1;
    req_valid = 1'b0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_use2  = 1'b0;
    rsp_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 0;

    vt[0] = '{1, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0};
    vt[1] = '{0, 5, 0, 1, 0, 32'hDEADBEEF, 0, 4};
    vt[2] = '{1, 0, 0, 0, 32'h1234, 0, 0, 0};
    vt[3] = '{0, 0, 0, 0, 0, 0, 0, 3};
    vt[4] = '{1, 31, 0, 0, 32'hA5A5A5A5, 0, 0, 0};
    vt[5] = '{0, 31, 5, 1, 0, 32'hA5A5A5A5,
              32'hDEADBEEF, 4};
    vt[6] = '{0, 5, 31, 0, 0, 32'hDEADBEEF, 0, 3};
    vt[7] = '{1, 5, 0, 0, 32'h0, 0, 0, 0};
    vt[8] = '{0, 31, 5, 1, 0, 32'hA5A5A5A5, 0, 4};
    vt[9] = '{0, 0, 31, 1, 0, 0, 32'hA5A5A5A5, 4};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_d", rf_d, 0);
    chk("rst_rsp_rs1", rsp_rs1, 0);
    chk("rst_rsp_rs2", rsp_rs2, 0);
    chk("rst_wb_ready", wb_ready, 1);
    rstn   = 1'b1;
    rf_clr = 1'b0;

    // Table-driven directed vectors.
    for (int k = 0; k < 10; k++) begin
      if (vt[k].is_wb) begin
        do_wb(vt[k].a, vt[k].d);
      end else begin
        issue(vt[k].a, vt[k].b, vt[k].use2);
        wait_rsp(vt[k].e1, vt[k].e2,
                 vt[k].lat, 0);
      end
    end

    // Writeback and request in the same cycle.
    @(negedge clk);
    wb_valid  = 1'b1;
    wb_rd     = 5'd7;
    wb_data   = 32'h55;
    req_valid = 1'b1;
    req_rs1   = 5'd7;
    req_rs2   = 5'd0;
    req_use2  = 1'b0;
    #1;
    chk("sim_rf_we", rf_we, 1);
    chk("sim_req_ready", req_ready, 0);
    @(negedge clk);
    wb_valid = 1'b0;
    ref_rf[7] = 32'h55;
    #1;
    chk("sim_req_pending", req_ready, 1);
    wait_rsp(32'h55, 0, 3, 0);

    // Consumer back-pressure for 6 cycles.
    issue(5'd31, 5'd7, 1'b1);
    wait_rsp(32'hA5A5A5A5, 32'h55, 4, 6);

    // Reset asserted while in CAP2.
    issue(5'd31, 5'd7, 1'b1);
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst2_rsp_valid", rsp_valid, 0);
    chk("rst2_idle", wb_ready, 1);
    chk("rst2_rsp_rs1", rsp_rs1, 0);
    chk("rst2_rf_we", rf_we, 0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    chk("rst2_no_rsp", seen, 0);
    issue(5'd7, 5'd31, 1'b1);
    wait_rsp(32'h55, 32'hA5A5A5A5, 4, 0);

    // Random mix against the shadow RF.
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_wb(5'($urandom_range(0, 31)),
              $urandom);
      end else begin
        logic [4:0] a, b;
        logic u;
        a = 5'($urandom_range(0, 31));
        b = 5'($urandom_range(0, 31));
        u = 1'($urandom_range(0, 1));
        issue(a, b, u);
        wait_rsp(ref_rf[a],
                 u ? ref_rf[b] : 32'h0,
                 u ? 4 : 3,
                 $urandom_range(0, 2));
      end
    end

    @(negedge clk);
    chk("rf_we_outside_idle", bad_we, 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
